// File: rtl/ifetch_unit.sv
// Instruction fetch: PC, single-outstanding imem request FSM, 2-entry queue feeding decode.
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirect target raises fetch_misaligned and halts fetch.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        fetch_misaligned
`endif
);
  localparam logic [1:0] QFULL = 2'(QDEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_addr_q;
  logic        req_valid_q;
  logic        drop_q;
  logic        halt_q;
  logic [31:0] q_inst_q [2];
  logic [31:0] q_pc_q   [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic        push;
  logic        pop;
  logic        tgt_misaligned;
  logic [31:0] tgt_pc;

`ifdef FETCH_MISALIGN_CHK_EN
  assign tgt_pc           = redirect_pc;
  assign tgt_misaligned   = |redirect_pc[1:0];
  assign fetch_misaligned = halt_q;
`else
  logic unused_tgt_lsb;
  assign tgt_pc         = {redirect_pc[31:2], 2'b00};
  assign tgt_misaligned = 1'b0;
  assign unused_tgt_lsb = ^redirect_pc[1:0];
`endif

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign inst_valid     = (count_q != 2'd0);
  assign inst           = inst_valid ? q_inst_q[rd_ptr_q] : 32'h0;
  assign inst_pc        = inst_valid ? q_pc_q[rd_ptr_q] : 32'h0;
  assign opcode         = inst[6:0];

  // Responses are never stalled: space was reserved before issue. Stale or redirect-cycle data is dropped.
  assign push    = (state_q == WAIT) && imem_rsp_valid && !drop_q && !redirect_valid;
  assign pop     = inst_valid && inst_ready;
  assign count_d = count_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (push) begin
      q_inst_q[wr_ptr_q] <= imem_rsp_data;
      q_pc_q[wr_ptr_q]   <= req_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
      drop_q      <= 1'b0;
      halt_q      <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else if (redirect_valid) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      pc_q        <= tgt_pc;
      req_valid_q <= 1'b0;
      halt_q      <= tgt_misaligned;
      // A request still owed a response must have that response swallowed before refetching.
      if ((state_q == WAIT && !imem_rsp_valid) || (req_valid_q && imem_req_ready)) begin
        drop_q  <= 1'b1;
        state_q <= WAIT;
      end else begin
        drop_q  <= 1'b0;
        state_q <= IDLE;
      end
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
      case (state_q)
        IDLE: begin
          if (!halt_q && count_q < QFULL) begin
            state_q     <= REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= pc_q;
          end
        end
        REQ: begin
          if (imem_req_ready) begin
            state_q     <= WAIT;
            req_valid_q <= 1'b0;
            pc_q        <= pc_q + 32'd4;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            drop_q <= 1'b0;
            if (!halt_q && count_d < QFULL) begin
              state_q     <= REQ;
              req_valid_q <= 1'b1;
              req_addr_q  <= pc_q;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
